// File: rtl/adder_tree_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_rr_sched
// Purpose  : Round-robin scheduler sharing one pipelined 8-operand adder tree
//            among NUM_REQ requesters. One requester is granted per cycle;
//            its operands are registered (S1), reduced by a 3-level
//            zero-extending adder tree, and the full-precision sum is
//            registered with the requester index (S2).
// Ports    : clk          rising-edge clock
//            rst_n        asynchronous active-low reset
//            req_valid_i  per-requester offer
//            req_data_i   per-requester packed operand set (8 x ADDER_WIDTH)
//            req_ready_o  one-hot (or zero) accept strobe
//            rsp_valid_o  result valid
//            rsp_id_o     index of the requester owning the result
//            rsp_sum_o    unsigned sum of the 8 operands (ADDER_WIDTH+3 bits)
//            rsp_ready_i  consumer accepts the result
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_rr_sched #(
  parameter  int ADDER_WIDTH = 6,
  parameter  int NUM_REQ     = 4,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ*8*ADDER_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic                             rsp_valid_o,
  output logic [IDW-1:0]                   rsp_id_o,
  output logic [ADDER_WIDTH+2:0]           rsp_sum_o,
  input  logic                             rsp_ready_i
);

  localparam int SETW = 8 * ADDER_WIDTH;
  localparam int SUMW = ADDER_WIDTH + 3;

  // Pipeline state
  logic [IDW-1:0]  ptr_q;
  logic            s1_valid_q;
  logic [IDW-1:0]  s1_id_q;
  logic [SETW-1:0] s1_data_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [SUMW-1:0] rsp_sum_q;

  // Next-state / combinational
  logic            en;
  logic            any_valid;
  logic            hi_found;
  logic [IDW-1:0]  hi_id;
  logic [IDW-1:0]  lo_id;
  logic [IDW-1:0]  win_id;
  logic [NUM_REQ-1:0] gnt;
  logic            accept;
  logic [IDW-1:0]  ptr_d;
  logic [SETW-1:0] s1_data_d;
  logic [SUMW-1:0] tree_sum;

  // Both stages move together; holding rst_n in the term forces req_ready low
  // while reset is asserted even though rsp_valid_q is already cleared.
  assign en = rst_n & (~rsp_valid_q | rsp_ready_i);

  // Rotating-priority search without a barrel rotate: scanning downward, the
  // last hit at or above ptr is the nearest index from ptr upward; the last
  // hit overall is the lowest index, used when nothing at/above ptr is valid
  // (the wrap-around case).
  always_comb begin
    any_valid = 1'b0;
    hi_found  = 1'b0;
    hi_id     = '0;
    lo_id     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
        any_valid = 1'b1;
        lo_id     = IDW'(i);
      end
    end
  end

  assign win_id      = hi_found ? hi_id : lo_id;
  assign gnt         = any_valid ? (NUM_REQ'(1) << win_id) : '0;
  assign req_ready_o = gnt & {NUM_REQ{en}};
  assign accept      = |req_ready_o;
  assign ptr_d       = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
  assign s1_data_d   = req_data_i[int'(win_id) * SETW +: SETW];

  // Three-level adder tree; each level widens by one bit so nothing overflows.
  logic [ADDER_WIDTH-1:0] op [8];
  logic [ADDER_WIDTH:0]   l3 [4];
  logic [ADDER_WIDTH+1:0] l2 [2];

  generate
    for (genvar k = 0; k < 8; k++) begin : g_op
      assign op[k] = s1_data_q[k*ADDER_WIDTH +: ADDER_WIDTH];
    end
    for (genvar p = 0; p < 4; p++) begin : g_l3
      assign l3[p] = {1'b0, op[2*p]} + {1'b0, op[2*p+1]};
    end
    for (genvar p = 0; p < 2; p++) begin : g_l2
      assign l2[p] = {1'b0, l3[2*p]} + {1'b0, l3[2*p+1]};
    end
  endgenerate

  assign tree_sum = {1'b0, l2[0]} + {1'b0, l2[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else if (en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q <= s1_data_d;
        s1_id_q   <= win_id;
        ptr_q     <= ptr_d;
      end
      rsp_valid_q <= s1_valid_q;
      rsp_id_q    <= s1_id_q;
      rsp_sum_q   <= tree_sum;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;

endmodule
`default_nettype wire
